// File: rtl/pmem_line_adapter.sv
// Bridges a 256-bit cacheline read/write port onto a 64-bit, 4-beat burst
// memory interface; memory may accept or deliver a beat on any cycle.
module pmem_line_adapter #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [31:0]  burst_address,
  output logic         burst_read,
  output logic         burst_write,
  input  logic [63:0]  burst_rdata,
  output logic [63:0]  burst_wdata,
  input  logic         burst_resp
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t       state;
  logic [1:0]   cnt;
  logic [31:0]  addr_q;
  logic [255:0] wline_q;
  logic [255:0] rline_q;

  // NOTE: the line registers are reset because the cache-facing outputs must
  // read as zero while rst is low; all state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      addr_q  <= 32'd0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Writeback wins over fill when the cache raises both.
          if (pmem_write) begin
            addr_q  <= pmem_address & ~32'h1f;
            wline_q <= pmem_wdata;
            cnt     <= 2'd0;
            state   <= WRITE;
          end else if (pmem_read) begin
            addr_q <= pmem_address & ~32'h1f;
            cnt    <= 2'd0;
            state  <= READ;
          end
        end
        READ: begin
          if (burst_resp) begin
            rline_q[{cnt, 6'd0} +: 64] <= burst_rdata;
            cnt <= cnt + 2'd1;
            if (cnt == LAST_BEAT) state <= DONE;
          end
        end
        WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + 2'd1;
            if (cnt == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so they are glitch-free and clean
  // to zero asynchronously with the registers above.
  assign pmem_resp     = (state == DONE);
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign burst_address = addr_q;
  assign burst_wdata   = wline_q[{cnt, 6'd0} +: 64];
  assign pmem_rdata    = rline_q;

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Directed self-checking bench for pmem_line_adapter with a small burst-memory
// responder whose acceptance spacing is selectable per transfer.
module tb_pmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_rdata;
  logic [63:0]  burst_wdata;
  logic         burst_resp;

  int n_cmp = 0;
  int n_bad = 0;

  pmem_line_adapter #(.BEATS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_rdata   (burst_rdata),
    .burst_wdata   (burst_wdata),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cache request serviced by the responder. The responder accepts a beat
  // on every period-th busy cycle; for reads, line supplies the beat data.
  // Request inputs are scrambled once the burst has started.
  task automatic xfer(input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] exp_addr, input logic [255:0] line,
                      input int period, input logic [255:0] keep,
                      output logic [255:0] got, output int lat, output int resp_cnt,
                      output int rd_cyc, output int wr_cyc);
    int k;
    int phase;
    int after;
    k = 0; phase = 0; after = 0;
    lat = -1; resp_cnt = 0; rd_cyc = 0; wr_cyc = 0; got = '0;
    pmem_address = a; pmem_read = rd; pmem_write = wr; pmem_wdata = line;
    for (int i = 0; i < 200 && after < 3; i++) begin
      @(posedge clk); #1;
      burst_resp = 1'b0;
      if (i == 1) begin
        pmem_address = ~a;
        pmem_wdata   = ~line;
      end
      if (pmem_resp) begin
        resp_cnt++;
        if (lat < 0) begin
          lat = i;
          got = pmem_rdata;
        end
        pmem_read = 1'b0;
        pmem_write = 1'b0;
      end
      if (lat >= 0) after++;
      if (burst_read || burst_write) begin
        if (burst_read) rd_cyc++;
        if (burst_write) wr_cyc++;
        check("burst_address", 256'(burst_address), 256'(exp_addr));
        if (burst_write) begin
          check("burst_wdata", 256'(burst_wdata), 256'(line[64*(k%4) +: 64]));
          check("rdata_kept_during_write", pmem_rdata, keep);
        end
        if ((phase % period) == period - 1 && k < 4) begin
          burst_resp  = 1'b1;
          burst_rdata = line[64*k +: 64];
          k++;
        end
        phase++;
      end
    end
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    burst_resp = 1'b0;
  endtask

  logic [255:0] line_r, line_w, line_e, line_f, got;
  int lat, resp_cnt, rd_cyc, wr_cyc, k;

  initial begin
    line_r = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_w = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
              64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    line_e = {64'hE3E3_E3E3_0000_0003, 64'hE2E2_E2E2_0000_0002,
              64'hE1E1_E1E1_0000_0001, 64'hE0E0_E0E0_0000_0000};
    line_f = {64'hF00D_0000_0000_0004, 64'hF00D_0000_0000_0003,
              64'hF00D_0000_0000_0002, 64'hF00D_0000_0000_0001};

    rst = 1'b0;
    pmem_address = 32'h0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
    burst_rdata = 64'h0; burst_resp = 1'b0;
    #12;
    check("reset_ctrl", 256'({pmem_resp, burst_read, burst_write}), 256'(3'b000));
    check("reset_addr_wdata", 256'({burst_address, burst_wdata}), 256'(0));
    check("reset_rdata", pmem_rdata, 256'(0));
    @(negedge clk); rst = 1'b1;

    // Stray beat acknowledgements with no request pending.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      burst_resp = 1'b1;
      burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      check("idle_quiet", 256'({pmem_resp, burst_read, burst_write}), 256'(3'b000));
    end
    @(posedge clk); #1;
    burst_resp = 1'b0;
    check("idle_after_spurious", 256'({pmem_resp, burst_read, burst_write}), 256'(3'b000));
    check("idle_rdata_untouched", pmem_rdata, 256'(0));

    // Back-to-back read: response 4 edges after the sampling edge (6 cycles).
    xfer(1'b0, 1'b1, 32'h0000_1234, 32'h0000_1220, line_r, 1, '0,
         got, lat, resp_cnt, rd_cyc, wr_cyc);
    check("read_line", got, line_r);
    check("read_latency", 256'(lat), 256'(4));
    check("read_resp_count", 256'(resp_cnt), 256'(1));
    check("read_beats", 256'(rd_cyc), 256'(4));
    check("read_no_write", 256'(wr_cyc), 256'(0));

    // Gapped write: a beat accepted every third cycle -> 12 busy cycles.
    xfer(1'b1, 1'b0, 32'h0000_ABCD, 32'h0000_ABC0, line_w, 3, line_r,
         got, lat, resp_cnt, rd_cyc, wr_cyc);
    check("write_resp_count", 256'(resp_cnt), 256'(1));
    check("write_cycles", 256'(wr_cyc), 256'(12));
    check("write_no_read", 256'(rd_cyc), 256'(0));
    check("rdata_after_write", pmem_rdata, line_r);

    // Read and write together: the write wins.
    xfer(1'b1, 1'b1, 32'h8000_0040, 32'h8000_0040, line_e, 1, line_r,
         got, lat, resp_cnt, rd_cyc, wr_cyc);
    check("both_no_read", 256'(rd_cyc), 256'(0));
    check("both_write_cycles", 256'(wr_cyc), 256'(4));
    check("both_resp_count", 256'(resp_cnt), 256'(1));
    check("both_latency", 256'(lat), 256'(4));

    // Reset after two read beats: everything clears, no response.
    pmem_address = 32'h0000_5678; pmem_read = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 2; i++) begin
      @(posedge clk); #1;
      burst_resp = 1'b0;
      if (burst_read) begin
        burst_resp = 1'b1;
        burst_rdata = 64'h5555_0000_0000_0000 + 64'(k);
        k++;
      end
    end
    @(posedge clk); #1;
    burst_resp = 1'b0;
    check("abort_two_beats_taken", 256'(k), 256'(2));
    rst = 1'b0;
    #1;
    check("abort_ctrl", 256'({pmem_resp, burst_read, burst_write}), 256'(3'b000));
    check("abort_addr_wdata", 256'({burst_address, burst_wdata}), 256'(0));
    check("abort_rdata", pmem_rdata, 256'(0));
    pmem_read = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (pmem_resp) resp_cnt++;
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    if (pmem_resp) resp_cnt++;
    check("abort_no_resp", 256'(resp_cnt), 256'(0));

    // Fresh read after the abort, beats every other cycle, top of address space.
    xfer(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, line_f, 2, '0,
         got, lat, resp_cnt, rd_cyc, wr_cyc);
    check("fresh_read_line", got, line_f);
    check("fresh_read_resp_count", 256'(resp_cnt), 256'(1));
    check("fresh_read_cycles", 256'(rd_cyc), 256'(8));
    check("fresh_rdata_held", pmem_rdata, line_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/pmem_line_adapter.md
PMEM_LINE_ADAPTER -- requirements
Module: pmem_line_adapter

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning number of 64-bit beats per 256-bit cacheline; only 4 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pmem_address, input, 32, cacheline request address from the cache.
REQ-005 SHALL have port pmem_read, input, 1, cacheline fill request, held by the cache until pmem_resp.
REQ-006 SHALL have port pmem_write, input, 1, cacheline writeback request, held by the cache until pmem_resp.
REQ-007 SHALL have port pmem_wdata, input, 256, writeback line.
REQ-008 SHALL have port pmem_rdata, output, 256, assembled fill line.
REQ-009 SHALL have port pmem_resp, output, 1, one-cycle completion pulse to the cache.
REQ-010 SHALL have port burst_address, output, 32, line-aligned address to memory.
REQ-011 SHALL have port burst_read, output, 1, burst read request to memory.
REQ-012 SHALL have port burst_write, output, 1, burst write request to memory.
REQ-013 SHALL have port burst_rdata, input, 64, read beat from memory.
REQ-014 SHALL have port burst_wdata, output, 64, write beat to memory.
REQ-015 SHALL have port burst_resp, input, 1, beat accepted (write) or beat valid (read) this cycle.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE, plus a 2-bit beat counter.
REQ-017 In IDLE, on pmem_write SHALL latch {pmem_address[31:5],5'b0}, latch pmem_wdata, clear counter, and go to WRITE; pmem_write SHALL take priority when pmem_read and pmem_write are both high.
REQ-018 In IDLE, on pmem_read with pmem_write low, SHALL latch the aligned address, clear counter, and go to READ.
REQ-019 In IDLE, burst_resp SHALL be ignored and the FSM SHALL remain in IDLE with no request.
REQ-020 burst_read SHALL be 1 only in READ and burst_write only in WRITE, both registered-state decodes; burst_address SHALL be the latched address, constant for the whole burst.
REQ-021 In READ, on each burst_resp, burst_rdata SHALL be stored into line bits [64k+63:64k], k = counter, and the counter SHALL increment; beats need not be consecutive.
REQ-022 In WRITE, burst_wdata SHALL be latched-line bits [64k+63:64k], k = counter; each burst_resp SHALL advance the counter.
REQ-023 The burst_resp for beat 3 SHALL move READ or WRITE to DONE; the counter SHALL wrap to 0.
REQ-024 In DONE, pmem_resp SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-025 pmem_rdata SHALL present the assembled line from DONE onward and hold it until the next read's first beat; a write SHALL not alter it.
REQ-026 A new request SHALL be accepted no earlier than the IDLE cycle after DONE; the cache deasserts its request in that cycle.
REQ-027 Minimum latency with burst_resp high every cycle SHALL be 6 cycles: request sampled at edge 0, beats at edges 1-4, pmem_resp high in cycle 5.
REQ-028 burst_resp outside READ/WRITE SHALL have no effect.
REQ-029 Request inputs changing mid-burst SHALL not affect the burst in progress.

Reset
REQ-030 While rst is 0, FSM SHALL be IDLE, counter 0, and pmem_resp, burst_read, burst_write, burst_address, burst_wdata, and pmem_rdata all 0, asynchronously.
REQ-031 rst asserted mid-burst SHALL abort the burst without a pmem_resp pulse; operation resumes in IDLE on the first edge after rst returns to 1.

Verification
REQ-032 Read, back-to-back beats: pmem_read, address 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_address 0x0000_1220, pmem_rdata = {44..,33..,22..,11..}, pmem_resp exactly one cycle, 6 cycles after request.
REQ-033 Write, gapped: pmem_write with line {D,C,B,A}, burst_resp high only every third cycle -> burst_wdata A,B,C,D each held until accepted, burst_write high throughout, one pmem_resp.
REQ-034 Simultaneous pmem_read and pmem_write in IDLE -> WRITE burst performed, burst_read never asserted.
REQ-035 rst low after 2 read beats -> all outputs 0 immediately, no pmem_resp; a following read completes normally with fresh data.
REQ-036 Spurious burst_resp in IDLE, then a read -> no state change in IDLE, read line correct.
REQ-037 Write following a read -> pmem_rdata retains the read line through and after the write.
